// File: rtl/execution_mc.sv
// Execute stage with single-cycle ALU/branch path and an iterative radix-2 multiply/divide unit.
// Results sit in one output register handed to the LSU with a valid/ready handshake.
package execution_mc_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_opcode_t;
endpackage

module execution_mc
  import execution_mc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int MD_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic              i_flush,
  input  alu_opcode_t       i_alu_opcode,
  input  logic [XLEN-1:0]   i_alu_op1,
  input  logic [XLEN-1:0]   i_alu_op2,
  input  logic              i_is_md,
  input  logic [2:0]        i_md_op,
  input  logic [4:0]        i_rd_id,
  input  logic              i_is_reg_write,
  input  logic              i_is_load,
  input  logic              i_is_store,
  input  logic              i_is_jump,
  input  logic              i_is_branch,
  input  logic [2:0]        i_branch_type,
  input  logic [2:0]        i_load_store_type,
  input  logic [XLEN-1:0]   i_jump_address,
  input  logic [XLEN-1:0]   i_store_data,
  output logic              o_branch_enable,
  output logic [XLEN-1:0]   o_branch_address,
  output logic              o_is_reg_write,
  output logic              o_is_mem_read,
  output logic              o_is_mem_write,
  output logic [4:0]        o_rd_id,
  output logic [2:0]        o_load_store_type,
  output logic [XLEN-1:0]   o_mem_address,
  output logic [XLEN-1:0]   o_mem_data,
  output logic [XLEN-1:0]   o_reg_data,
  output logic              o_dbg_state
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            state_q;
  logic              valid_q, ben_q, rw_q, mr_q, mw_q;
  logic [4:0]        rd_q;
  logic [2:0]        lst_q;
  logic [XLEN-1:0]   baddr_q, maddr_q, mdata_q, rdata_q;

  logic [2:0]        md_op_q;
  logic              md_neg_q, md_rneg_q, md_div0_q, md_rw_q;
  logic [4:0]        md_rd_q;
  logic [2:0]        md_lst_q;
  logic [XLEN-1:0]   md_b_q, md_hi_q, md_lo_q, md_hi_d, md_lo_d;
  logic [CW-1:0]     cnt_q;

  logic [XLEN-1:0]   alu_res;
  logic              taken, accept, md_go;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot, rem, md_res;

  // Handshake: an op is taken when i_valid && o_ready; a result leaves when o_valid && i_ready.
  assign o_ready = (state_q == S_IDLE) && (!valid_q || i_ready);
  assign accept  = i_valid && o_ready;
  assign md_go   = i_is_md && (MD_EN != 0);

  always_comb begin
    alu_res = '0;
    case (i_alu_opcode)
      ALU_ADD:  alu_res = i_alu_op1 + i_alu_op2;
      ALU_SUB:  alu_res = i_alu_op1 - i_alu_op2;
      ALU_SLL:  alu_res = i_alu_op1 << i_alu_op2[SHW-1:0];
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(i_alu_op1) < $signed(i_alu_op2)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, i_alu_op1 < i_alu_op2};
      ALU_XOR:  alu_res = i_alu_op1 ^ i_alu_op2;
      ALU_SRL:  alu_res = i_alu_op1 >> i_alu_op2[SHW-1:0];
      ALU_SRA:  alu_res = $unsigned($signed(i_alu_op1) >>> i_alu_op2[SHW-1:0]);
      ALU_OR:   alu_res = i_alu_op1 | i_alu_op2;
      ALU_AND:  alu_res = i_alu_op1 & i_alu_op2;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    if (i_is_branch) begin
      case (i_branch_type)
        3'b000:  taken = (alu_res == '0);
        3'b001:  taken = (alu_res != '0);
        3'b100:  taken = $signed(i_alu_op1) < $signed(i_alu_op2);
        3'b101:  taken = $signed(i_alu_op1) >= $signed(i_alu_op2);
        3'b110:  taken = i_alu_op1 < i_alu_op2;
        3'b111:  taken = i_alu_op1 >= i_alu_op2;
        default: taken = 1'b0;
      endcase
    end
    if (i_is_jump) taken = 1'b1;
  end

  // The MD unit works on magnitudes; signs are reapplied on the final cycle.
  always_comb begin
    a_signed = (i_md_op != 3'b011) && (i_md_op != 3'b101) && (i_md_op != 3'b111);
    b_signed = a_signed && (i_md_op != 3'b010);
    a_neg    = a_signed && i_alu_op1[XLEN-1];
    b_neg    = b_signed && i_alu_op2[XLEN-1];
    a_mag    = a_neg ? -i_alu_op1 : i_alu_op1;
    b_mag    = b_neg ? -i_alu_op2 : i_alu_op2;
  end

  always_comb begin
    mul_sum   = {1'b0, md_hi_q} + (md_lo_q[0] ? {1'b0, md_b_q} : '0);
    div_shift = {md_hi_q, md_lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, md_b_q};
    if (md_op_q[2]) begin
      if (!div_diff[XLEN]) begin
        md_hi_d = div_diff[XLEN-1:0];
        md_lo_d = {md_lo_q[XLEN-2:0], 1'b1};
      end else begin
        md_hi_d = div_shift[XLEN-1:0];
        md_lo_d = {md_lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      md_hi_d = mul_sum[XLEN:1];
      md_lo_d = {mul_sum[0], md_lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = md_neg_q ? -{md_hi_d, md_lo_d} : {md_hi_d, md_lo_d};
    quot     = md_div0_q ? '1 : (md_neg_q ? -md_lo_d : md_lo_d);
    rem      = md_rneg_q ? -md_hi_d : md_hi_d;
    case (md_op_q)
      3'b000:                 md_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: md_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         md_res = quot;
      default:                md_res = rem;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      ben_q     <= 1'b0;
      rw_q      <= 1'b0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
      rd_q      <= '0;
      lst_q     <= '0;
      baddr_q   <= '0;
      maddr_q   <= '0;
      mdata_q   <= '0;
      rdata_q   <= '0;
      md_op_q   <= '0;
      md_neg_q  <= 1'b0;
      md_rneg_q <= 1'b0;
      md_div0_q <= 1'b0;
      md_rw_q   <= 1'b0;
      md_rd_q   <= '0;
      md_lst_q  <= '0;
      md_b_q    <= '0;
      md_hi_q   <= '0;
      md_lo_q   <= '0;
      cnt_q     <= '0;
    end else if (i_flush) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      ben_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && md_go) begin
            state_q   <= S_BUSY;
            valid_q   <= 1'b0;
            ben_q     <= 1'b0;
            cnt_q     <= '0;
            md_op_q   <= i_md_op;
            md_neg_q  <= a_neg ^ b_neg;
            md_rneg_q <= a_neg;
            md_div0_q <= (i_alu_op2 == '0);
            md_rw_q   <= i_is_reg_write;
            md_rd_q   <= i_rd_id;
            md_lst_q  <= i_load_store_type;
            md_hi_q   <= '0;
            md_b_q    <= i_md_op[2] ? b_mag : a_mag;
            md_lo_q   <= i_md_op[2] ? a_mag : b_mag;
          end else if (accept) begin
            // With MD disabled an MD op lands here and writes 0 with no side effects.
            valid_q <= 1'b1;
            ben_q   <= taken && !i_is_md;
            baddr_q <= i_jump_address;
            rw_q    <= i_is_reg_write || (i_is_load && !i_is_md);
            mr_q    <= i_is_load && !i_is_md;
            mw_q    <= i_is_store && !i_is_md;
            rd_q    <= i_rd_id;
            lst_q   <= i_load_store_type;
            maddr_q <= ((i_is_load || i_is_store) && !i_is_md) ? alu_res : '0;
            mdata_q <= (i_is_store && !i_is_md) ? i_store_data : '0;
            rdata_q <= (i_is_reg_write && !i_is_load && !i_is_md) ? alu_res : '0;
          end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
            ben_q   <= 1'b0;
          end
        end
        S_BUSY: begin
          md_hi_q <= md_hi_d;
          md_lo_q <= md_lo_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= S_IDLE;
            valid_q <= 1'b1;
            ben_q   <= 1'b0;
            baddr_q <= '0;
            rw_q    <= md_rw_q;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            rd_q    <= md_rd_q;
            lst_q   <= md_lst_q;
            maddr_q <= '0;
            mdata_q <= '0;
            rdata_q <= md_rw_q ? md_res : '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_valid           = valid_q;
  assign o_branch_enable   = ben_q;
  assign o_branch_address  = baddr_q;
  assign o_is_reg_write    = rw_q;
  assign o_is_mem_read     = mr_q;
  assign o_is_mem_write    = mw_q;
  assign o_rd_id           = rd_q;
  assign o_load_store_type = lst_q;
  assign o_mem_address     = maddr_q;
  assign o_mem_data        = mdata_q;
  assign o_reg_data        = rdata_q;
  assign o_dbg_state       = (state_q == S_BUSY);

endmodule

// File: tb/tb_execution_mc.sv
// Bench for execution_mc: directed corner cases followed by random ops checked
// against an arithmetic reference model through an expected-result queue.
module tb_execution_mc;
  import execution_mc_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  typedef struct {
    alu_opcode_t opc;
    logic [W-1:0] a, b, jaddr, sdata;
    logic is_md;
    logic [2:0] md_op, bt, lst;
    logic [4:0] rd;
    logic rw, ld, st, jmp, br;
  } op_t;

  typedef struct {
    logic rw, mr, mw, ben;
    logic [4:0] rd;
    logic [2:0] lst;
    logic [W-1:0] maddr, mdata, rdata, baddr;
  } res_t;

  logic i_clk = 1'b0;
  logic i_rst_n, i_valid, i_ready, i_flush;
  alu_opcode_t i_alu_opcode;
  logic [W-1:0] i_alu_op1, i_alu_op2, i_jump_address, i_store_data;
  logic i_is_md, i_is_reg_write, i_is_load, i_is_store, i_is_jump, i_is_branch;
  logic [2:0] i_md_op, i_branch_type, i_load_store_type;
  logic [4:0] i_rd_id;
  logic o_ready, o_valid, o_branch_enable, o_is_reg_write, o_is_mem_read, o_is_mem_write, o_dbg_state;
  logic [W-1:0] o_branch_address, o_mem_address, o_mem_data, o_reg_data;
  logic [4:0] o_rd_id;
  logic [2:0] o_load_store_type;

  res_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  execution_mc #(.XLEN(W), .MD_EN(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .o_valid(o_valid), .i_ready(i_ready), .i_flush(i_flush),
    .i_alu_opcode(i_alu_opcode), .i_alu_op1(i_alu_op1), .i_alu_op2(i_alu_op2),
    .i_is_md(i_is_md), .i_md_op(i_md_op), .i_rd_id(i_rd_id),
    .i_is_reg_write(i_is_reg_write), .i_is_load(i_is_load), .i_is_store(i_is_store),
    .i_is_jump(i_is_jump), .i_is_branch(i_is_branch), .i_branch_type(i_branch_type),
    .i_load_store_type(i_load_store_type), .i_jump_address(i_jump_address),
    .i_store_data(i_store_data), .o_branch_enable(o_branch_enable),
    .o_branch_address(o_branch_address), .o_is_reg_write(o_is_reg_write),
    .o_is_mem_read(o_is_mem_read), .o_is_mem_write(o_is_mem_write), .o_rd_id(o_rd_id),
    .o_load_store_type(o_load_store_type), .o_mem_address(o_mem_address),
    .o_mem_data(o_mem_data), .o_reg_data(o_reg_data), .o_dbg_state(o_dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] alu_ref(input alu_opcode_t opc, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    case (opc)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return (sa < sb) ? 1 : 0;
      ALU_SLTU: return (a < b) ? 1 : 0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return sa >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 0;
    endcase
  endfunction

  function automatic logic branch_ref(input op_t op);
    logic signed [W-1:0] sa, sb;
    logic zero;
    sa = op.a;
    sb = op.b;
    zero = (alu_ref(op.opc, op.a, op.b) == 0);
    if (op.jmp) return 1'b1;
    if (!op.br) return 1'b0;
    case (op.bt)
      3'd0: return zero;
      3'd1: return !zero;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return op.a < op.b;
      3'd7: return op.a >= op.b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] md_ref(input logic [2:0] mop, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] sa, ua, sb, ub, p;
    logic signed [W-1:0] xa, xb, r;
    sa = {{W{a[W-1]}}, a};
    ua = {{W{1'b0}}, a};
    sb = {{W{b[W-1]}}, b};
    ub = {{W{1'b0}}, b};
    xa = a;
    xb = b;
    case (mop)
      3'd0: begin p = sa * sb; return p[W-1:0]; end
      3'd1: begin p = sa * sb; return p[2*W-1:W]; end
      3'd2: begin p = sa * ub; return p[2*W-1:W]; end
      3'd3: begin p = ua * ub; return p[2*W-1:W]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == MIN && b == '1) return MIN;
        r = xa / xb;
        return r;
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == '1) return 0;
        r = xa % xb;
        return r;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic res_t ref_res(input op_t op);
    res_t e;
    logic [W-1:0] alu;
    alu = alu_ref(op.opc, op.a, op.b);
    e.rd = op.rd;
    e.lst = op.lst;
    if (op.is_md) begin
      e.rw = op.rw; e.mr = 0; e.mw = 0; e.ben = 0;
      e.maddr = 0; e.mdata = 0; e.baddr = 0;
      e.rdata = op.rw ? md_ref(op.md_op, op.a, op.b) : 0;
    end else begin
      e.rw = op.rw || op.ld;
      e.mr = op.ld;
      e.mw = op.st;
      e.ben = branch_ref(op);
      e.baddr = op.jaddr;
      e.maddr = (op.ld || op.st) ? alu : 0;
      e.mdata = op.st ? op.sdata : 0;
      e.rdata = (op.rw && !op.ld) ? alu : 0;
    end
    return e;
  endfunction

  function automatic op_t blank_op();
    op_t o;
    o.opc = ALU_ADD; o.a = 0; o.b = 0; o.jaddr = 0; o.sdata = 0; o.is_md = 0;
    o.md_op = 0; o.bt = 0; o.lst = 0; o.rd = 0;
    o.rw = 0; o.ld = 0; o.st = 0; o.jmp = 0; o.br = 0;
    return o;
  endfunction

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return '1;
      3: return MIN;
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o = blank_op();
    o.opc = alu_opcode_t'($urandom_range(0, 9));
    o.a = pick_val();
    o.b = pick_val();
    o.jaddr = $urandom;
    o.sdata = $urandom;
    o.rd = 5'($urandom_range(0, 31));
    o.lst = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0: o.rw = 1;
      1: begin o.ld = 1; o.rw = 1; end
      2: o.st = 1;
      3: begin o.br = 1; o.bt = 3'($urandom_range(0, 7)); end
      4: begin o.jmp = 1; o.rw = 1; end
      default: begin o.is_md = 1; o.md_op = 3'($urandom_range(0, 7)); o.rw = ($urandom_range(0, 7) != 0); end
    endcase
    return o;
  endfunction

  // ---------------- driver and checker tasks ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input op_t op);
    i_alu_opcode = op.opc; i_alu_op1 = op.a; i_alu_op2 = op.b;
    i_jump_address = op.jaddr; i_store_data = op.sdata;
    i_is_md = op.is_md; i_md_op = op.md_op; i_rd_id = op.rd;
    i_is_reg_write = op.rw; i_is_load = op.ld; i_is_store = op.st;
    i_is_jump = op.jmp; i_is_branch = op.br;
    i_branch_type = op.bt; i_load_store_type = op.lst;
    i_valid = 1'b1;
  endtask

  task automatic accept(input string tag, input op_t op);
    bit done;
    done = 0;
    drive(op);
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      if (o_ready) done = 1;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    if (!done) check({tag, ".accept_timeout"}, {31'd0, o_ready}, 1);
  endtask

  task automatic wait_valid(input string tag, output int n, output int rdy);
    n = 0;
    rdy = 0;
    while (!o_valid && n < 200) begin
      if (o_ready) rdy++;
      cyc();
      n++;
    end
    if (!o_valid) check({tag, ".valid_timeout"}, {31'd0, o_valid}, 1);
  endtask

  task automatic check_res(input string tag, input res_t e);
    check({tag, ".valid"}, o_valid, 1);
    check({tag, ".reg_data"}, o_reg_data, e.rdata);
    check({tag, ".rd_id"}, o_rd_id, e.rd);
    check({tag, ".reg_write"}, o_is_reg_write, e.rw);
    check({tag, ".mem_read"}, o_is_mem_read, e.mr);
    check({tag, ".mem_write"}, o_is_mem_write, e.mw);
    check({tag, ".mem_addr"}, o_mem_address, e.maddr);
    check({tag, ".mem_data"}, o_mem_data, e.mdata);
    check({tag, ".ls_type"}, o_load_store_type, e.lst);
    check({tag, ".br_en"}, o_branch_enable, e.ben);
    check({tag, ".br_addr"}, o_branch_address, e.baddr);
  endtask

  task automatic run_md(input string tag, input logic [2:0] mop, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] want);
    op_t o;
    int n, rdy;
    o = blank_op();
    o.is_md = 1; o.md_op = mop; o.a = a; o.b = b; o.rw = 1; o.rd = 5'd9;
    i_ready = 1'b1;
    accept(tag, o);
    // Operand changes while busy must not disturb the latched op.
    i_alu_op1 = $urandom;
    i_alu_op2 = $urandom;
    i_md_op = ~mop;
    wait_valid(tag, n, rdy);
    check({tag, ".latency"}, n + 1, W + 1);
    check({tag, ".ready_while_busy"}, rdy, 0);
    check({tag, ".value"}, o_reg_data, want);
    check_res(tag, ref_res(o));
    cyc();
    check({tag, ".consumed"}, o_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    op_t o, o2;
    res_t e;
    int n, rdy, vcount, hold;

    i_rst_n = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
    drive(blank_op());
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst.valid", o_valid, 0);
    check("rst.br_en", o_branch_enable, 0);
    check("rst.reg_data", o_reg_data, 0);
    check("rst.mem_addr", o_mem_address, 0);
    check("rst.reg_write", o_is_reg_write, 0);
    check("rst.br_addr", o_branch_address, 0);
    i_rst_n = 1'b1;
    cyc();
    check("rst.ready_after", o_ready, 1);

    // ADD 5+7
    o = blank_op();
    o.opc = ALU_ADD; o.a = 5; o.b = 7; o.rd = 3; o.rw = 1;
    i_ready = 1'b1;
    accept("add", o);
    wait_valid("add", n, rdy);
    check("add.latency", n + 1, 1);
    check("add.value", o_reg_data, 12);
    check("add.rd", o_rd_id, 3);
    check_res("add", ref_res(o));
    cyc();
    check("add.consumed", o_valid, 0);

    // BLT / BLTU with -1 vs 1
    o = blank_op();
    o.opc = ALU_SUB; o.a = '1; o.b = 1; o.br = 1; o.bt = 3'b100; o.jaddr = 32'h100;
    accept("blt", o);
    check("blt.br_en", o_branch_enable, 1);
    check("blt.br_addr", o_branch_address, 32'h100);
    check_res("blt", ref_res(o));
    cyc();
    check("blt.br_en_after", o_branch_enable, 0);
    o.bt = 3'b110;
    accept("bltu", o);
    check("bltu.br_en", o_branch_enable, 0);
    check("bltu.valid", o_valid, 1);
    cyc();

    // back-to-back non-MD ops with no bubble
    o = blank_op();
    o.opc = ALU_XOR; o.a = 32'hF0F0_1234; o.b = 32'h0FF0_FFFF; o.rw = 1; o.rd = 7;
    o2 = blank_op();
    o2.opc = ALU_SRA; o2.a = 32'h8000_0010; o2.b = 4; o2.rw = 1; o2.rd = 8;
    accept("b2b0", o);
    check_res("b2b0", ref_res(o));
    accept("b2b1", o2);
    check_res("b2b1", ref_res(o2));
    cyc();
    check("b2b.drained", o_valid, 0);

    // MD corner cases
    run_md("div_ovf", 3'b100, MIN, '1, MIN);
    run_md("rem_ovf", 3'b110, MIN, '1, 0);
    run_md("divu_0", 3'b101, 7, 0, '1);
    run_md("rem_0", 3'b110, 32'hFFFF_FFF9, 0, 32'hFFFF_FFF9);
    run_md("mulhu", 3'b011, '1, '1, 32'hFFFF_FFFE);
    run_md("mulh", 3'b001, '1, '1, 0);
    run_md("mul", 3'b000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
    run_md("div_neg", 3'b100, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD);

    // store held under back-pressure
    o = blank_op();
    o.opc = ALU_ADD; o.a = 32'h1000; o.b = 32'h24; o.st = 1; o.sdata = 32'hCAFE_F00D; o.lst = 3'b010;
    e = ref_res(o);
    i_ready = 1'b0;
    accept("st", o);
    for (int k = 0; k < 4; k++) begin
      check_res("st_hold", e);
      check("st_hold.ready", o_ready, 0);
      cyc();
    end
    i_ready = 1'b1;
    cyc();
    check("st.consumed", o_valid, 0);

    // flush while busy, with a competing op offered at the flush edge
    o = blank_op();
    o.is_md = 1; o.md_op = 3'b100; o.a = 100; o.b = 7; o.rw = 1; o.rd = 4;
    accept("flush_md", o);
    repeat (10) cyc();
    o2 = blank_op();
    o2.opc = ALU_ADD; o2.a = 1; o2.b = 2; o2.rw = 1; o2.rd = 5;
    drive(o2);
    i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush.valid", o_valid, 0);
    check("flush.ready", o_ready, 1);
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) vcount++;
      cyc();
    end
    check("flush.no_result", vcount, 0);
    // flush in idle drops a same-cycle acceptance
    drive(o2);
    i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_idle.valid", o_valid, 0);
    run_md("after_flush", 3'b110, 100, 7, 2);

    // reset pulse in the middle of a multiply
    o = blank_op();
    o.is_md = 1; o.md_op = 3'b011; o.a = 32'h1234_5678; o.b = 32'h9ABC_DEF0; o.rw = 1; o.rd = 6;
    accept("rst_md", o);
    repeat (5) cyc();
    i_rst_n = 1'b0;
    #1;
    check("rst_mid.valid", o_valid, 0);
    check("rst_mid.reg_data", o_reg_data, 0);
    cyc();
    i_rst_n = 1'b1;
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) vcount++;
      cyc();
    end
    check("rst_mid.no_result", vcount, 0);
    run_md("after_rst", 3'b010, '1, 3, '1);

    // random ops against the reference model
    for (int t = 0; t < 60; t++) begin
      o = rand_op();
      i_ready = 1'b0;
      accept("rnd", o);
      exp_q.push_back(ref_res(o));
      wait_valid("rnd", n, rdy);
      check("rnd.latency", n + 1, o.is_md ? W + 1 : 1);
      e = exp_q.pop_front();
      check_res("rnd", e);
      hold = $urandom_range(0, 2);
      for (int k = 0; k < hold; k++) begin
        cyc();
        check("rnd.hold_valid", o_valid, 1);
        check("rnd.hold_data", o_reg_data, e.rdata);
      end
      i_ready = 1'b1;
      cyc();
      check("rnd.consumed", o_valid, 0);
      check("rnd.br_cleared", o_branch_enable, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/execution_mc.md
EXECUTION_MC -- requirements
Module: execution_mc

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32 and 64.
REQ-002 Parameter MD_EN, default 1: 1 instantiates the iterative multiply/divide unit; 0 treats MD ops as NOP writes of 0.
REQ-003 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_valid / o_ready  in / out  1 / 1  upstream handshake; an op is accepted when both are high.
REQ-006 o_valid / i_ready  out / in  1 / 1  downstream (LSU) handshake; a result is consumed when both are high.
REQ-007 i_flush  in  1  discards the in-flight op and the output register.
REQ-008 i_alu_opcode  in  alu_opcode_t  ALU operation; i_alu_op1, i_alu_op2  in  XLEN  operands.
REQ-009 i_is_md  in  1  selects the MD unit; i_md_op  in  3  RV M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-010 i_rd_id  in  5; i_is_reg_write, i_is_load, i_is_store, i_is_jump, i_is_branch  in  1 each.
REQ-011 i_branch_type  in  3; i_load_store_type  in  3; i_jump_address, i_store_data  in  XLEN.
REQ-012 o_branch_enable  out  1 and o_branch_address  out  XLEN: redirect to IF.
REQ-013 o_is_reg_write, o_is_mem_read, o_is_mem_write  out  1; o_rd_id  out  5; o_load_store_type  out  3.
REQ-014 o_mem_address, o_mem_data, o_reg_data  out  XLEN: registered results to the LSU.

Function
REQ-015 FSM states: IDLE, BUSY. o_ready SHALL equal (state==IDLE) && (!o_valid || i_ready).
REQ-016 Non-MD ops: accept in IDLE; load the output register on the same edge, so the result appears 1 cycle after acceptance, with o_valid=1.
REQ-017 Output decode SHALL match the single-cycle stage. Reg write without load: o_reg_data = ALU result. Load: mem_read=1, reg_write=1, address = ALU result. Store: mem_write=1, address = ALU result, data = i_store_data. Unused data outputs = 0.
REQ-018 Branch conditions SHALL be evaluated on accepted ops:
  - BEQ/BNE on zero flag.
  - BLT/BGE signed.
  - BLTU/BGEU unsigned.
  - Jump forces taken.
  - Funct3 values 010/011 give not-taken.
REQ-019 o_branch_enable SHALL be a registered signal, high only while o_valid=1 for a taken op. o_branch_address = the registered i_jump_address.
REQ-020 MD ops (MD_EN=1): accept in IDLE, go to BUSY, run one radix-2 iteration per cycle for XLEN cycles, then load the output register and return to IDLE. Latency is XLEN+1 cycles.
REQ-021 MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-022 Divide by zero:
  - quotient = all ones (DIV and DIVU);
  - remainder = dividend.
REQ-023 Signed overflow (DIV of most-negative by -1): quotient = most-negative, remainder = 0.
REQ-024 Operand signs and the op SHALL be latched at acceptance. Operand changes during BUSY have no effect.
REQ-025 o_valid held while i_ready=0: all outputs stable and no new acceptance.
REQ-026 Consumption with no new acceptance in the same cycle: o_valid falls next cycle.
REQ-027 Consumption with a new acceptance in the same cycle (non-MD): the output register is overwritten with no bubble.
REQ-028 i_flush, highest priority: o_valid←0, o_branch_enable←0, FSM→IDLE, and any same-cycle acceptance is dropped.

Reset
REQ-029 While i_rst_n=0: state=IDLE and every registered output = 0, including o_valid and o_branch_enable. o_ready SHALL be 1 from the first edge after release.
REQ-030 Reset asserted mid-BUSY SHALL abort the op, with no result ever presented.

Verification
REQ-031 ADD op1=5, op2=7, rd=3, reg_write; i_ready=1 -> next cycle o_valid=1, o_reg_data=12, o_rd_id=3, o_is_reg_write=1.
REQ-032 BLT op1=0xFFFFFFFF, op2=1, jump_address=0x100 -> o_branch_enable=1 with address 0x100. BLTU with the same operands -> 0.
REQ-033 DIV 0x80000000 by 0xFFFFFFFF -> after 33 cycles o_reg_data=0x80000000. REM of the same operands -> 0. DIVU 7/0 -> 0xFFFFFFFF.
REQ-034 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH of the same operands -> 0x00000000. During BUSY, o_ready=0.
REQ-035 Hold i_ready=0 for 4 cycles with a store pending -> outputs stable and o_ready=0. Release -> consumed, o_valid falls.
REQ-036 i_flush at BUSY cycle 10, and i_rst_n pulsed during BUSY -> o_valid never rises for the flushed op and the next op completes correctly.
